// File: rtl/gate_mode_if.sv
// Pin-side bundle for the gate-mode sequencer: raw switches/button in, mode and LED indicators out.
// The board side drives through master; the sequencer connects as slave.
interface gate_mode_if;
  logic [3:0] sw;
  logic       btn;
  logic       auto_en;
  logic [1:0] mode;
  logic [3:0] ld;
  logic       res;

  modport master (output sw, output btn, output auto_en,
                  input mode, input ld, input res);
  modport slave  (input sw, input btn, input auto_en,
                  output mode, output ld, output res);
endinterface

// File: rtl/gate_mode_sequencer.sv
// Selects which 4-input reduction (AND/OR/XOR/NOR) of the synchronized switches drives the result LED,
// stepping on a debounced button press or on an auto-scan period.
//
// state | meaning
// M_AND | result = &sw
// M_OR  | result = |sw
// M_XOR | result = ^sw
// M_NOR | result = ~|sw
module gate_mode_sequencer #(
  parameter int DEB_CYC  = 4,
  parameter int SCAN_DIV = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  gate_mode_if.slave  io
);

  localparam int DW = (DEB_CYC  > 2) ? $clog2(DEB_CYC)  : 1;
  localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {M_AND = 2'd0, M_OR = 2'd1, M_XOR = 2'd2, M_NOR = 2'd3} mode_t;

  mode_t         state_q, state_d;
  logic [3:0]    sw_m_q, sw_s_q;
  logic          btn_m_q, btn_s_q;
  logic          btn_db_q, btn_db_d, btn_db_dly_q;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic          res_q, res_d;
  logic          press, tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_m_q       <= '0;
      sw_s_q       <= '0;
      btn_m_q      <= 1'b0;
      btn_s_q      <= 1'b0;
      btn_db_q     <= 1'b0;
      btn_db_dly_q <= 1'b0;
      deb_cnt_q    <= '0;
      scan_cnt_q   <= '0;
      state_q      <= M_AND;
      res_q        <= 1'b0;
    end else begin
      sw_m_q       <= io.sw;
      sw_s_q       <= sw_m_q;
      btn_m_q      <= io.btn;
      btn_s_q      <= btn_m_q;
      btn_db_q     <= btn_db_d;
      btn_db_dly_q <= btn_db_q;
      deb_cnt_q    <= deb_cnt_d;
      scan_cnt_q   <= scan_cnt_d;
      state_q      <= state_d;
      res_q        <= res_d;
    end
  end

  // Any sample that agrees with the debounced level restarts the stability window.
  always_comb begin
    deb_cnt_d = '0;
    btn_db_d  = btn_db_q;
    if (btn_s_q != btn_db_q) begin
      if (deb_cnt_q == DW'(DEB_CYC - 1)) btn_db_d = btn_s_q;
      else                               deb_cnt_d = deb_cnt_q + DW'(1);
    end
  end

  assign press = btn_db_q & ~btn_db_dly_q;
  assign tick  = io.auto_en & (scan_cnt_q == SW'(SCAN_DIV - 1));

  // A press restarts the scan period so a manual step is never followed by an immediate auto step.
  always_comb begin
    scan_cnt_d = '0;
    if (io.auto_en && !press && !tick) scan_cnt_d = scan_cnt_q + SW'(1);
  end

  always_comb begin
    state_d = state_q;
    if (press || tick) begin
      case (state_q)
        M_AND:   state_d = M_OR;
        M_OR:    state_d = M_XOR;
        M_XOR:   state_d = M_NOR;
        M_NOR:   state_d = M_AND;
        default: state_d = M_AND;
      endcase
    end
  end

  always_comb begin
    res_d = 1'b0;
    case (state_q)
      M_AND:   res_d = &sw_s_q;
      M_OR:    res_d = |sw_s_q;
      M_XOR:   res_d = ^sw_s_q;
      M_NOR:   res_d = ~|sw_s_q;
      default: res_d = 1'b0;
    endcase
  end

  assign io.mode = state_q;
  assign io.ld   = 4'b0001 << state_q;
  assign io.res  = res_q;

endmodule

// File: tb/tb_gate_mode_sequencer.sv
// Bench for gate_mode_sequencer: directed latency/boundary scenarios plus randomized pin activity,
// all checked against a behavioural reference of the pin-level rules.
module tb_gate_mode_sequencer;
  localparam int DEB_CYC  = 4;
  localparam int SCAN_DIV = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  gate_mode_if bus ();

  gate_mode_sequencer #(.DEB_CYC(DEB_CYC), .SCAN_DIV(SCAN_DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  always #5 clk = ~clk;

  // reference: pin pipelines, debounced level and its history, scan phase, mode, result
  logic [3:0] m_sw1, m_sw2;
  bit m_b1, m_b2, m_db, m_dbp, m_res;
  int m_run, m_phase, m_mode;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit reduce(input int mode, input logic [3:0] s);
    case (mode)
      0: return &s;
      1: return |s;
      2: return ^s;
      default: return ~|s;
    endcase
  endfunction

  task automatic model_reset();
    m_sw1 = '0; m_sw2 = '0; m_b1 = 0; m_b2 = 0; m_db = 0; m_dbp = 0;
    m_res = 0; m_run = 0; m_phase = 0; m_mode = 0;
  endtask

  task automatic model_step();
    bit press, tick;
    int nm;
    press = m_db && !m_dbp;
    tick  = bus.auto_en && (m_phase == SCAN_DIV - 1);
    m_res = reduce(m_mode, m_sw2);
    nm    = (press || tick) ? (m_mode + 1) % 4 : m_mode;
    m_phase = (!bus.auto_en || press) ? 0 : (m_phase + 1) % SCAN_DIV;
    m_dbp = m_db;
    if (m_b2 != m_db) begin
      m_run++;
      if (m_run == DEB_CYC) begin m_db = m_b2; m_run = 0; end
    end else m_run = 0;
    m_sw2 = m_sw1; m_sw1 = bus.sw;
    m_b2 = m_b1;   m_b1 = bus.btn;
    m_mode = nm;
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      model_step();
      chk("mode", bus.mode, m_mode);
      chk("ld", bus.ld, 32'd1 << m_mode);
      chk("res", bus.res, m_res);
    end
  endtask

  // Asserts reset between edges, checks the immediate clear, releases on the next falling edge.
  task automatic async_reset();
    #3 rst_n = 1'b0;
    #1 model_reset();
    chk("rst_mode", bus.mode, 0);
    chk("rst_ld", bus.ld, 4'b0001);
    chk("rst_res", bus.res, 0);
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic wait_step(output int n, input int max_c);
    logic [1:0] m0;
    m0 = bus.mode;
    n = -1;
    for (int i = 1; i <= max_c; i++) begin
      cyc(1);
      if (bus.mode != m0) begin n = i; break; end
    end
  endtask

  task automatic press();
    bus.btn = 1'b1; cyc(10);
    bus.btn = 1'b0; cyc(10);
  endtask

  initial begin
    int n;
    logic [1:0] m0;
    bus.sw = 4'hF; bus.btn = 1'b0; bus.auto_en = 1'b0;
    model_reset();
    #1;
    chk("init_mode", bus.mode, 0);
    chk("init_ld", bus.ld, 4'b0001);
    chk("init_res", bus.res, 0);
    @(negedge clk) rst_n = 1'b1;

    // 1: async reset mid-operation from mode 2
    cyc(4);
    press(); press();
    chk("t1_mode2", bus.mode, 2);
    async_reset();
    cyc(3);
    chk("t1_res_after_rel", bus.res, 1);

    // 2: reduction sweep on 1011, then all-zero in NOR mode
    bus.sw = 4'b1011; cyc(4);
    chk("t2_and", bus.res, 0);
    press(); chk("t2_or", bus.res, 1);
    press(); chk("t2_xor", bus.res, 1);
    press(); chk("t2_nor", bus.res, 0);
    bus.sw = 4'b0000; cyc(2);
    chk("t2_nor_hold", bus.res, 0);
    cyc(1);
    chk("t2_nor_zero", bus.res, 1);

    // 3: bouncy button, then stable hold
    async_reset();
    bus.btn = 1'b1; cyc(2); bus.btn = 1'b0; cyc(2);
    bus.btn = 1'b1; cyc(2); bus.btn = 1'b0; cyc(2);
    chk("t3_bounce_mode", bus.mode, 0);
    bus.btn = 1'b1;
    wait_step(n, 20);
    chk("t3_press_lat", n, 7);
    chk("t3_mode", bus.mode, 1);
    cyc(100);
    chk("t3_hold_mode", bus.mode, 1);
    bus.btn = 1'b0; cyc(10);
    chk("t3_release_mode", bus.mode, 1);

    // 4: auto-scan with wrap, pause and resume
    async_reset();
    bus.auto_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_step(n, 20);
      chk("t4_period", n, 8);
      chk("t4_mode", bus.mode, (k + 1) % 4);
    end
    cyc(5);
    bus.auto_en = 1'b0; cyc(6);
    chk("t4_frozen", bus.mode, 0);
    bus.auto_en = 1'b1;
    wait_step(n, 20);
    chk("t4_resume", n, 8);

    // 5: press lands on the tick edge
    cyc(1);
    m0 = bus.mode;
    bus.btn = 1'b1;
    wait_step(n, 20);
    chk("t5_collide_lat", n, 7);
    chk("t5_single_step", bus.mode, (m0 + 1) % 4);
    wait_step(n, 20);
    chk("t5_next_tick", n, 8);
    bus.btn = 1'b0; bus.auto_en = 1'b0; cyc(10);

    // 6: reset in the middle of a debounce window
    async_reset();
    bus.btn = 1'b1; cyc(5);
    async_reset();
    wait_step(n, 20);
    chk("t6_fresh_window", n, 7);
    chk("t6_mode", bus.mode, 1);
    bus.btn = 1'b0; cyc(10);

    // random pin activity
    async_reset();
    for (int i = 0; i < 300; i++) begin
      bus.sw = 4'($urandom);
      if ($urandom_range(0, 2) == 0) bus.btn = ~bus.btn;
      if ($urandom_range(0, 5) == 0) bus.auto_en = ~bus.auto_en;
      cyc($urandom_range(1, 12));
      if ($urandom_range(0, 60) == 0) async_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/gate_mode_sequencer.md
Name: gate_mode_sequencer

Overview:
- Board-level controller for the 4-switch reduction-gate lab datapath (AND, OR, XOR, NOR of sw[3:0]).
- Synchronizes the switches and a mode button, and debounces the button.
- Sequences which of the four reductions drives the result LED, either by button press or by automatic timed scanning.
- Sits between the board I/O pins and the LED outputs; one clock domain.

Parameters:
- DEB_CYC, 4, consecutive stable cycles required before the debounced button changes (min 2).
- SCAN_DIV, 8, cycles per mode step in auto-scan (min 2).

Ports:
- clk  input  1  system clock; all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- sw  input  4  raw switch inputs, asynchronous to clk
- btn  input  1  raw mode-advance button, asynchronous, active-high, bouncy
- auto_en  input  1  1 = auto-scan modes every SCAN_DIV cycles; treated as synchronous
- mode  output  2  current mode: 0 AND, 1 OR, 2 XOR, 3 NOR
- ld  output  4  one-hot mode indicator, ld[mode]=1
- res  output  1  registered result of selected reduction on synchronized switches

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (rst_n); all flops clear immediately on rst_n=0.
  - Reset values: mode=0, ld=4'b0001, res=0.
  - Sync flops, debounce state, edge history and scan counter all clear to 0.
- Reset mid-operation aborts any debounce count or scan period. After release, the next press needs a full DEB_CYC stable window.
- Synchronizers: 2-flop synchronizer on each sw bit and on btn; outputs are sw_s and btn_s.
- Debounce:
  - Counter cnt_d has width clog2(DEB_CYC).
  - If btn_s == btn_db, cnt_d is cleared.
  - Otherwise, if cnt_d == DEB_CYC-1, btn_db <= btn_s and cnt_d clears; else cnt_d increments.
  - Any glitch back to btn_db restarts the window.
- Press detect: press = btn_db & ~btn_db_q, where btn_db_q is btn_db delayed one cycle. press is a single-cycle pulse on the rising edge only; release does nothing.
- Scan counter cnt_s (0..SCAN_DIV-1):
  - auto_en=0: cnt_s held at 0, no tick.
  - auto_en=1: cnt_s increments each cycle; tick = (cnt_s == SCAN_DIV-1), after which cnt_s wraps to 0.
  - press clears cnt_s to 0, restarting a full period.
- Mode FSM, states M_AND(0) -> M_OR(1) -> M_XOR(2) -> M_NOR(3) -> M_AND (wrap-around):
  - Advances by exactly one step on any edge where press or tick is 1.
  - press and tick in the same cycle produce a single step.
- ld: combinational one-hot decode of the mode register; always exactly one bit set.
- res, registered each cycle from the current mode and sw_s:
  - AND: &sw_s
  - OR: |sw_s
  - XOR: ^sw_s
  - NOR: ~|sw_s
- Latency:
  - sw pin change to res: 3 edges.
  - btn rise (stable) to btn_db: 2+DEB_CYC edges; mode/ld update at edge 3+DEB_CYC; res reflects the new mode at edge 4+DEB_CYC.
  - Mode change to res: 1 cycle.
- A button held indefinitely causes only one step. auto_en toggling mid-period discards the partial count.

Test Plan (DEB_CYC=4, SCAN_DIV=8):
1. Reset: rst_n=0 asynchronously mid-cycle with sw=4'hF, mode=2 -> immediately mode=0, ld=0001, res=0. After release with sw=4'hF, res=1 within 3 edges.
2. Reduction sweep: step mode through 0..3 by clean presses with sw=4'b1011 -> res = 0, 1, 1, 0. Then sw=4'b0000 in mode 3 -> res=1 three edges after the switch change.
3. Debounce: btn toggles 1,0,1 with 2-cycle pulses, then holds 1 -> no mode change during bounce. mode 0->1 exactly at edge 7 counted from the start of the stable high. Holding btn 100 cycles -> no further step.
4. Auto-scan: auto_en=1 from mode 0 -> mode steps every 8 cycles: 1, 2, 3, 0 wrap. auto_en=0 at cnt_s=5 -> mode frozen and cnt_s=0. Re-enable -> next step after a full 8 cycles.
5. Collision: press pulse coincides with tick (cnt_s=7) -> mode advances by exactly 1 and cnt_s=0. Next tick follows 8 cycles later.
6. Reset during debounce: rst_n pulsed after 3 stable btn-high cycles -> no step after release until btn is stable high for a fresh 2+4 edges window; mode stays 0 until then.
